// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle MIPS datapath: decodes op/funct and sequences
// every datapath control input, with configurable memory wait states and halt.
module multicycle_ctrl #(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6,
  parameter int MEM_LAT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               halt,
  output logic               PCEn,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUsrcA,
  output logic [1:0]         ALUsrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         PCsrc,
  output logic               illegal,
  output logic               instr_done
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, BRANCH, ADDIWB, JUMP
  } stateT;

  localparam logic [3:0]      LAT     = 4'(MEM_LAT);
  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);

  // Returns {valid, aluControl}; unknown functs fall back to add.
  function automatic logic [3:0] decodeFunct(input logic [FUNCT_W-1:0] f);
    logic [3:0] res;
    case (f)
      FUNCT_W'(6'h20): res = {1'b1, 3'b010};
      FUNCT_W'(6'h22): res = {1'b1, 3'b110};
      FUNCT_W'(6'h24): res = {1'b1, 3'b000};
      FUNCT_W'(6'h25): res = {1'b1, 3'b001};
      FUNCT_W'(6'h2A): res = {1'b1, 3'b111};
      default:         res = {1'b0, 3'b010};
    endcase
    return res;
  endfunction

  stateT      stateR, stateNextS;
  logic [3:0] waitCntR, waitCntNextS;
  logic       memStateS, haltedS, lastCycleS;
  logic [3:0] functDecS;

  logic       pcEnS, iorDS, memWriteS, irWriteS, regDstS, memtoRegS, regWriteS, aluSrcAS;
  logic [1:0] aluSrcBS, pcSrcS;
  logic [2:0] aluControlS;
  logic       illegalS, instrDoneS;

  assign memStateS  = (stateR == FETCH) || (stateR == MEMRD) || (stateR == MEMWR);
  // Halt is only honoured at the instruction boundary, before any wait state.
  assign haltedS    = (stateR == FETCH) && (waitCntR == 4'd0) && halt;
  assign lastCycleS = memStateS ? ((waitCntR == LAT) && !haltedS) : 1'b1;
  assign functDecS  = decodeFunct(funct);

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateR   <= FETCH;
      waitCntR <= 4'd0;
    end else begin
      stateR   <= stateNextS;
      waitCntR <= waitCntNextS;
    end
  end

  // Next-state and wait-counter decode.
  always_comb begin
    stateNextS = stateR;
    case (stateR)
      FETCH:  stateNextS = lastCycleS ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW, OP_ADDI: stateNextS = MEMADR;
          OP_RTYPE:              stateNextS = EXEC;
          OP_BEQ:                stateNextS = BRANCH;
          OP_J:                  stateNextS = JUMP;
          default:               stateNextS = FETCH;
        endcase
      end
      MEMADR: begin
        case (op)
          OP_LW:   stateNextS = MEMRD;
          OP_SW:   stateNextS = MEMWR;
          default: stateNextS = ADDIWB;
        endcase
      end
      MEMRD:  stateNextS = lastCycleS ? MEMWB : MEMRD;
      MEMWR:  stateNextS = lastCycleS ? FETCH : MEMWR;
      EXEC:   stateNextS = ALUWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: stateNextS = FETCH;
      default: stateNextS = FETCH;
    endcase

    if (stateNextS != stateR) begin
      waitCntNextS = 4'd0;
    end else if (memStateS && !haltedS) begin
      waitCntNextS = waitCntR + 4'd1;
    end else begin
      waitCntNextS = waitCntR;
    end
  end

  // Per-state control decode; strobes in memory states fire only on the last cycle.
  always_comb begin
    pcEnS       = 1'b0;
    iorDS       = 1'b0;
    memWriteS   = 1'b0;
    irWriteS    = 1'b0;
    regDstS     = 1'b0;
    memtoRegS   = 1'b0;
    regWriteS   = 1'b0;
    aluSrcAS    = 1'b0;
    aluSrcBS    = 2'b00;
    aluControlS = 3'b000;
    pcSrcS      = 2'b00;
    illegalS    = 1'b0;
    instrDoneS  = 1'b0;
    case (stateR)
      FETCH: begin
        aluSrcBS    = 2'b01;
        aluControlS = 3'b010;
        irWriteS    = lastCycleS;
        pcEnS       = lastCycleS;
      end
      DECODE: begin
        aluSrcBS    = 2'b11;
        aluControlS = 3'b010;
        case (op)
          OP_LW, OP_SW, OP_ADDI, OP_RTYPE, OP_BEQ, OP_J: illegalS = 1'b0;
          default:                                      illegalS = 1'b1;
        endcase
        instrDoneS = illegalS;
      end
      MEMADR: begin
        aluSrcAS    = 1'b1;
        aluSrcBS    = 2'b10;
        aluControlS = 3'b010;
      end
      MEMRD: iorDS = 1'b1;
      MEMWB: begin
        memtoRegS  = 1'b1;
        regWriteS  = 1'b1;
        instrDoneS = 1'b1;
      end
      MEMWR: begin
        iorDS      = 1'b1;
        memWriteS  = lastCycleS;
        instrDoneS = lastCycleS;
      end
      EXEC: begin
        aluSrcAS    = 1'b1;
        aluControlS = functDecS[2:0];
        illegalS    = !functDecS[3];
      end
      ALUWB: begin
        regDstS    = 1'b1;
        regWriteS  = 1'b1;
        instrDoneS = 1'b1;
      end
      ADDIWB: begin
        regWriteS  = 1'b1;
        instrDoneS = 1'b1;
      end
      BRANCH: begin
        aluSrcAS    = 1'b1;
        aluControlS = 3'b110;
        pcSrcS      = 2'b01;
        pcEnS       = zero;
        instrDoneS  = 1'b1;
      end
      JUMP: begin
        pcSrcS     = 2'b10;
        pcEnS      = 1'b1;
        instrDoneS = 1'b1;
      end
      default: begin
        aluSrcBS    = 2'b01;
        aluControlS = 3'b010;
      end
    endcase
  end

  // Strobes and pulses are suppressed while reset is held; mux selects pass through.
  assign PCEn       = pcEnS & rst;
  assign IRWrite    = irWriteS & rst;
  assign MemWrite   = memWriteS & rst;
  assign RegWrite   = regWriteS & rst;
  assign illegal    = illegalS & rst;
  assign instr_done = instrDoneS & rst;
  assign IorD       = iorDS;
  assign RegDst     = regDstS;
  assign MemtoReg   = memtoRegS;
  assign ALUsrcA    = aluSrcAS;
  assign ALUsrcB    = aluSrcBS;
  assign ALUControl = aluControlS;
  assign PCsrc      = pcSrcS;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: per instruction the expected per-cycle control words are
// queued from a sequence table, then popped and compared cycle by cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       halt;

  logic pcEn0, iorD0, memWr0, irWr0, regDst0, memtoReg0, regWr0, aluA0, ill0, done0;
  logic [1:0] aluB0, pcSrc0;
  logic [2:0] aluCtl0;
  logic pcEn2, iorD2, memWr2, irWr2, regDst2, memtoReg2, regWr2, aluA2, ill2, done2;
  logic [1:0] aluB2, pcSrc2;
  logic [2:0] aluCtl2;

  logic [17:0] w0, w2;
  logic [17:0] expQ[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.OP_W(6), .FUNCT_W(6), .MEM_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .halt(halt),
    .PCEn(pcEn0), .IorD(iorD0), .MemWrite(memWr0), .IRWrite(irWr0), .RegDst(regDst0),
    .MemtoReg(memtoReg0), .RegWrite(regWr0), .ALUsrcA(aluA0), .ALUsrcB(aluB0),
    .ALUControl(aluCtl0), .PCsrc(pcSrc0), .illegal(ill0), .instr_done(done0)
  );

  multicycle_ctrl #(.OP_W(6), .FUNCT_W(6), .MEM_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .halt(halt),
    .PCEn(pcEn2), .IorD(iorD2), .MemWrite(memWr2), .IRWrite(irWr2), .RegDst(regDst2),
    .MemtoReg(memtoReg2), .RegWrite(regWr2), .ALUsrcA(aluA2), .ALUsrcB(aluB2),
    .ALUControl(aluCtl2), .PCsrc(pcSrc2), .illegal(ill2), .instr_done(done2)
  );

  assign w0 = {pcEn0, iorD0, memWr0, irWr0, regDst0, memtoReg0, regWr0, aluA0,
               aluB0, aluCtl0, pcSrc0, ill0, done0};
  assign w2 = {pcEn2, iorD2, memWr2, irWr2, regDst2, memtoReg2, regWr2, aluA2,
               aluB2, aluCtl2, pcSrc2, ill2, done2};

  function automatic logic [17:0] cw(
    input logic pe, input logic id, input logic mw, input logic iw,
    input logic rd, input logic mr, input logic rw, input logic aa,
    input logic [1:0] ab, input logic [2:0] ac, input logic [1:0] ps,
    input logic il, input logic dn);
    return {pe, id, mw, iw, rd, mr, rw, aa, ab, ac, ps, il, dn};
  endfunction

  task automatic checkVal(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Pops one expected word per cycle and compares at the falling edge.
  task automatic drain(input string tag, input int lat);
    logic [17:0] exp;
    while (expQ.size() > 0) begin
      @(negedge clk);
      exp = expQ.pop_front();
      checkVal(tag, (lat == 0) ? w0 : w2, exp);
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [17:0] idleFetch();
    return cw(0,0,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0, 0);
  endfunction

  task automatic pushFetch(input int lat);
    for (int i = 0; i < lat; i++) expQ.push_back(idleFetch());
    expQ.push_back(cw(1,0,0,1,0,0,0,0, 2'b01, 3'b010, 2'b00, 0, 0));
  endtask

  task automatic pushMem(input int lat, input logic isWrite);
    for (int i = 0; i < lat; i++) expQ.push_back(cw(0,1,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0, 0));
    expQ.push_back(cw(0,1,isWrite,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0, isWrite));
  endtask

  task automatic runInstr(input string tag, input logic [5:0] o, input logic [5:0] f,
                          input logic z, input int lat);
    logic [17:0] memAdr;
    logic [2:0]  alu;
    logic        bad;
    op = o; funct = f; zero = z;
    memAdr = cw(0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0, 0);
    pushFetch(lat);
    case (o)
      6'h23, 6'h2B, 6'h08, 6'h00, 6'h04, 6'h02:
        expQ.push_back(cw(0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0, 0));
      default:
        expQ.push_back(cw(0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 1, 1));
    endcase
    case (o)
      6'h23: begin
        expQ.push_back(memAdr);
        pushMem(lat, 1'b0);
        expQ.push_back(cw(0,0,0,0,0,1,1,0, 2'b00, 3'b000, 2'b00, 0, 1));
      end
      6'h2B: begin
        expQ.push_back(memAdr);
        pushMem(lat, 1'b1);
      end
      6'h08: begin
        expQ.push_back(memAdr);
        expQ.push_back(cw(0,0,0,0,0,0,1,0, 2'b00, 3'b000, 2'b00, 0, 1));
      end
      6'h00: begin
        bad = 1'b0;
        case (f)
          6'h20: alu = 3'b010;
          6'h22: alu = 3'b110;
          6'h24: alu = 3'b000;
          6'h25: alu = 3'b001;
          6'h2A: alu = 3'b111;
          default: begin alu = 3'b010; bad = 1'b1; end
        endcase
        expQ.push_back(cw(0,0,0,0,0,0,0,1, 2'b00, alu, 2'b00, bad, 0));
        expQ.push_back(cw(0,0,0,0,1,0,1,0, 2'b00, 3'b000, 2'b00, 0, 1));
      end
      6'h04: expQ.push_back(cw(z,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, 0, 1));
      6'h02: expQ.push_back(cw(1,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b10, 0, 1));
      default: ;
    endcase
    drain(tag, lat);
  endtask

  initial begin
    rst = 1'b0; op = 6'h00; funct = 6'h20; zero = 1'b0; halt = 1'b0;
    @(posedge clk);
    #1;
    expQ.push_back(idleFetch());
    drain("reset_l0", 0);
    expQ.push_back(idleFetch());
    drain("reset_l2", 2);
    rst = 1'b1;

    runInstr("lw_l0",     6'h23, 6'h00, 1'b0, 0);
    runInstr("rsub_l0",   6'h00, 6'h22, 1'b0, 0);
    runInstr("radd_l0",   6'h00, 6'h20, 1'b0, 0);
    runInstr("rand_l0",   6'h00, 6'h24, 1'b0, 0);
    runInstr("ror_l0",    6'h00, 6'h25, 1'b0, 0);
    runInstr("rslt_l0",   6'h00, 6'h2A, 1'b0, 0);
    runInstr("rbad_l0",   6'h00, 6'h3F, 1'b0, 0);
    runInstr("beq1_l0",   6'h04, 6'h00, 1'b1, 0);
    runInstr("beq0_l0",   6'h04, 6'h00, 1'b0, 0);
    runInstr("sw_l0",     6'h2B, 6'h00, 1'b0, 0);
    runInstr("addi_l0",   6'h08, 6'h00, 1'b0, 0);
    runInstr("j_l0",      6'h02, 6'h00, 1'b0, 0);
    runInstr("illop_l0",  6'h3F, 6'h00, 1'b0, 0);

    halt = 1'b1;
    for (int i = 0; i < 4; i++) expQ.push_back(idleFetch());
    drain("halt_l0", 0);
    halt = 1'b0;
    runInstr("resume_l0", 6'h23, 6'h00, 1'b0, 0);

    // Abort a lw while it sits in MEMRD.
    op = 6'h23;
    pushFetch(0);
    expQ.push_back(cw(0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0, 0));
    expQ.push_back(cw(0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0, 0));
    drain("lwpre_l0", 0);
    rst = 1'b0;
    expQ.push_back(idleFetch());
    expQ.push_back(idleFetch());
    drain("midrst_l0", 0);
    rst = 1'b1;
    runInstr("after_rst", 6'h00, 6'h25, 1'b0, 0);

    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    runInstr("sw_l2",     6'h2B, 6'h00, 1'b0, 2);
    runInstr("lw_l2",     6'h23, 6'h00, 1'b0, 2);
    runInstr("rsub_l2",   6'h00, 6'h22, 1'b0, 2);
    runInstr("beq1_l2",   6'h04, 6'h00, 1'b1, 2);
    runInstr("addi_l2",   6'h08, 6'h00, 1'b0, 2);
    runInstr("illop_l2",  6'h3F, 6'h00, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised control finite-state machine for the multicycle MIPS processor. It replaces hand-sequenced control stimulus on `dataPath`. It decodes the instruction register's opcode and funct fields and drives every datapath control input cycle by cycle. It supports lw, sw, R-type (add/sub/and/or/slt), beq, addi and j, with a configurable memory wait-state count and a halt request.

## Interface
- `OP_W`, default 6: opcode field width.
- `FUNCT_W`, default 6: funct field width.
- `MEM_LAT`, default 0: extra wait cycles inserted in every memory-access state, range 0–15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `op` in `OP_W`: opcode from the instruction register.
- `funct` in `FUNCT_W`: funct field from the instruction register.
- `zero` in 1: ALU zero flag.
- `halt` in 1: request to stop at an instruction boundary.
- `PCEn` out 1: PC write enable.
- `IorD` out 1: memory address select. 0 selects PC; 1 selects ALUOut.
- `MemWrite` out 1: memory write strobe.
- `IRWrite` out 1: instruction register write strobe.
- `RegDst` out 1: destination register select. 0 selects rt; 1 selects rd.
- `MemtoReg` out 1: register write-data select. 0 selects ALUOut; 1 selects memory data.
- `RegWrite` out 1: register file write strobe.
- `ALUsrcA` out 1: ALU A operand select. 0 selects PC; 1 selects register A.
- `ALUsrcB` out 2: ALU B operand select. 00 = register B, 01 = constant 1, 10 = sign-extended immediate, 11 = sign-extended immediate (branch offset).
- `ALUControl` out 3: ALU operation. 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `PCsrc` out 2: next-PC select. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal` out 1: one-cycle pulse on an unknown opcode or unknown funct.
- `instr_done` out 1: one-cycle pulse in the final cycle of each instruction.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIWB, JUMP.
- Memory states are FETCH, MEMRD and MEMWR.
  - Each occupies `1+MEM_LAT` cycles, counted by a wait counter that clears on state entry.
  - Mux selects are held for the whole state.
  - Strobes (IRWrite, PCEn, MemWrite) assert only in the final cycle.
- FETCH: IorD=0, ALUsrcA=0, ALUsrcB=01, ALUControl=010, PCsrc=00. In the final cycle IRWrite=1 and PCEn=1, then go to DECODE.
- halt in FETCH:
  - If halt=1 in the first FETCH cycle, stay in FETCH with all strobes 0.
  - Re-evaluate halt every cycle.
  - The wait counter does not advance while halted.
- DECODE: ALUsrcA=0, ALUsrcB=11, ALUControl=010 (branch target precomputed into ALUOut). Next state by opcode:
  - 0x23 or 0x2B → MEMADR
  - 0x00 → EXEC
  - 0x04 → BRANCH
  - 0x08 → MEMADR (addi shares the address computation)
  - 0x02 → JUMP
  - any other → FETCH, with illegal=1 and instr_done=1
- MEMADR: ALUsrcA=1, ALUsrcB=10, ALUControl=010. Next state: lw → MEMRD, sw → MEMWR, addi → ADDIWB.
- MEMRD: IorD=1, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, then FETCH.
- MEMWR: IorD=1, MemWrite=1 in the final cycle, then FETCH.
- EXEC: ALUsrcA=1, ALUsrcB=00, ALUControl from funct, then ALUWB.
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - Any other funct: ALUControl=010 and illegal=1 for this cycle; the instruction still completes.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, then FETCH.
- BRANCH: ALUsrcA=1, ALUsrcB=00, ALUControl=110, PCsrc=01, PCEn=zero (combinational), then FETCH.
- JUMP: PCsrc=10, PCEn=1, then FETCH.
- Signals not listed for a state are 0.
- Outputs are Moore-decoded from state and wait counter. The exceptions are `PCEn` in BRANCH and `ALUControl`/`illegal` in EXEC, which are combinational on inputs.

## Timing
- Reset asserted: state=FETCH, counter=0, and all strobes (PCEn, IRWrite, MemWrite, RegWrite), illegal and instr_done are forced 0. FETCH mux values are driven.
- Instruction latencies with L=`MEM_LAT`:
  - lw 5+2L
  - sw 4+2L
  - R-type 4+L
  - addi 4+L
  - beq 3+L
  - j 3+L
  - illegal opcode 2+L
- instr_done asserts in the final cycle of MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP, or in DECODE for an illegal opcode.
- Reset mid-instruction: the FSM returns to FETCH immediately and no strobe is issued in the reset cycle.
- halt outside FETCH is ignored until the next FETCH entry.

## Test plan
- Reset with L=0, then op=0x23 (lw): FETCH strobes IRWrite=PCEn=1 in cycle 1; MEMRD in cycle 4 has IorD=1; cycle 5 has RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1.
- R-type op=0x00, funct=0x22: EXEC has ALUControl=110; ALUWB has RegDst=1 and RegWrite=1; total 4 cycles.
- beq op=0x04: with zero=1, BRANCH gives PCEn=1 and PCsrc=01; with zero=0, PCEn=0; both take 3 cycles.
- MEM_LAT=2, sw op=0x2B: FETCH lasts 3 cycles with IRWrite only in the third; MemWrite is high only in the last of 3 MEMWR cycles; total 8 cycles.
- Illegal op=0x3F gives illegal=1 and a return to FETCH after DECODE. funct=0x3F gives illegal=1 in EXEC with ALUControl=010.
- halt=1 held 4 cycles in FETCH gives no IRWrite/PCEn. Releasing it resumes a normal fetch. Dropping rst in MEMRD gives state FETCH and RegWrite stays 0.
